pic_intc: RTL and testbench

PIC_INTC -- requirements
Module: pic_intc

---
 rtl/pic_intc_pkg.sv | 13 +
 rtl/pic_intc_sync.sv | 28 ++
 rtl/pic_intc.sv | 142 ++++++++++++++
 tb/tb_pic_intc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_intc_pkg.sv
// Shared types and default sizing for the pic_intc interrupt controller.
package pic_intc_pkg;

  localparam int NSRC_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/pic_intc_sync.sv
// One interrupt source: multi-flop synchronizer followed by a rising-edge detect flop.
module pic_intc_sync
  import pic_intc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic src,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/pic_intc.sv
// Edge-triggered interrupt controller: sync, pending latch, enable mask, arbitration, REQ/SERVICE handshake.
// Build option: define PIC_INTC_RR_EN for round-robin arbitration instead of fixed lowest-index priority.
module pic_intc
  import pic_intc_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int VEC_W       = $clog2(NSRC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_src,
  input  logic             en_wr,
  input  logic [NSRC-1:0]  en_din,
  output logic [NSRC-1:0]  en_q,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic [NSRC-1:0]  pending,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   en_r;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   eligible;
  logic [VEC_W-1:0]  search_start;
  logic [VEC_W-1:0]  winner;
  logic              ack_fire;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    pic_intc_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clock(clock),
      .reset(reset),
      .src  (irq_src[g]),
      .rise (rise[g])
    );
  end

  // First eligible source found scanning upward (with wrap) from start.
  function automatic logic [VEC_W-1:0] pick(input logic [NSRC-1:0] req,
                                           input logic [VEC_W-1:0] start);
    logic [VEC_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      idx = (int'(start) + i) % NSRC;
      if (!found && req[idx]) begin
        sel   = VEC_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef PIC_INTC_RR_EN
  logic [VEC_W-1:0] rr_ptr;

  // Pointer starts at the last index so the first search begins at source 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= VEC_W'(NSRC - 1);
    end else if (ack_fire) begin
      rr_ptr <= vec_q;
    end
  end

  assign search_start = (rr_ptr == VEC_W'(NSRC - 1)) ? '0 : rr_ptr + 1'b1;
`else
  assign search_start = '0;
`endif

  assign eligible = pending_q & en_r;
  assign winner   = pick(eligible, search_start);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    irq      = 1'b0;
    busy     = 1'b0;
    ack_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          vec_d   = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        irq = 1'b1;
        if (irq_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        busy = 1'b1;
        if (irq_eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge wins over a same-cycle clear so that interrupt is not lost.
  always_comb begin
    pending_d = pending_q;
    if (ack_fire) begin
      pending_d[vec_q] = 1'b0;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      pending_q <= '0;
      en_r      <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
      if (en_wr) begin
        en_r <= en_din;
      end
    end
  end

  assign en_q    = en_r;
  assign irq_vec = vec_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_pic_intc.sv
// Directed plus randomized bench for pic_intc against a sample-history reference model.
module tb_pic_intc;

  localparam int NSRC = 4;
  localparam int S    = 2;
  localparam int VW   = 2;

  logic            clock;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic            en_wr;
  logic [NSRC-1:0] en_din;
  logic [NSRC-1:0] en_q;
  logic            irq;
  logic [VW-1:0]   irq_vec;
  logic            irq_ack;
  logic            irq_eoi;
  logic [NSRC-1:0] pending;
  logic            busy;

  pic_intc #(
    .NSRC(NSRC),
    .SYNC_STAGES(S)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .irq_src(irq_src),
    .en_wr  (en_wr),
    .en_din (en_din),
    .en_q   (en_q),
    .irq    (irq),
    .irq_vec(irq_vec),
    .irq_ack(irq_ack),
    .irq_eoi(irq_eoi),
    .pending(pending),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: 0 idle, 1 requesting, 2 in service; hist[0] is the newest source sample.
  int              mstate;
  logic [NSRC-1:0] mpend;
  logic [NSRC-1:0] men;
  int              mvec;
  int              mlast;
  logic [NSRC-1:0] hist [0:S];

  int vectors;
  int miscompares;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mstate = 0;
    mpend  = '0;
    men    = '0;
    mvec   = 0;
    mlast  = NSRC - 1;
    for (int j = 0; j <= S; j++) hist[j] = '0;
  endtask

  function automatic int chooseSource(input logic [NSRC-1:0] req);
    int first;
    int k;
`ifdef PIC_INTC_RR_EN
    first = (mlast + 1) % NSRC;
`else
    first = 0;
`endif
    for (int n = 0; n < NSRC; n++) begin
      k = (first + n) % NSRC;
      if (req[k]) return k;
    end
    return 0;
  endfunction

  task automatic modelEdge();
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] npend;
    edges = hist[S-1] & ~hist[S];
    npend = mpend;
    case (mstate)
      0: if ((mpend & men) != 0) begin
           mvec   = chooseSource(mpend & men);
           mstate = 1;
         end
      1: if (irq_ack) begin
           npend[mvec] = 1'b0;
           mlast       = mvec;
           mstate      = 2;
         end
      default: if (irq_eoi) mstate = 0;
    endcase
    mpend = npend | edges;
    if (en_wr) men = en_din;
    for (int j = S; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = irq_src;
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] src, input logic wr,
                               input logic [NSRC-1:0] din, input logic ack, input logic eoi);
    irq_src = src;
    en_wr   = wr;
    en_din  = din;
    irq_ack = ack;
    irq_eoi = eoi;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("irq", 32'(irq), 32'(mstate == 1));
    checkOutput("busy", 32'(busy), 32'(mstate == 2));
    checkOutput("pending", 32'(pending), 32'(mpend));
    checkOutput("en_q", 32'(en_q), 32'(men));
    if (mstate != 0) checkOutput("irq_vec", 32'(irq_vec), 32'(mvec));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_vec", 32'(irq_vec), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_en_q", 32'(en_q), 32'd0);
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int expv;
    vectors     = 0;
    miscompares = 0;
    irq_src = '0; en_wr = 1'b0; en_din = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    reset = 1'b1;
    modelReset();
    #2;
    doReset();

    // Single source: request visible after the fourth edge, then ack and eoi.
    applyStimulus('0, 1'b1, 4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(2);
    checkOutput("lat_early", 32'(irq), 32'd0);
    idle(1);
    checkOutput("lat_irq", 32'(irq), 32'd1);
    checkOutput("lat_vec", 32'(irq_vec), 32'd2);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("ack_pending", 32'(pending), 32'd0);
    checkOutput("ack_busy", 32'(busy), 32'd1);
    idle(2);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("eoi_irq", 32'(irq), 32'd0);
    checkOutput("eoi_busy", 32'(busy), 32'd0);

    // Simultaneous edges on 1 and 3.
    applyStimulus(4'b1010, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    checkOutput("pair_first", 32'(irq_vec), 32'd1);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);
    checkOutput("pair_second", 32'(irq_vec), 32'd3);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);

    // Serve source 1 alone, then edges on 1 and 3 together.
    applyStimulus(4'b0010, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(4'b1010, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
`ifdef PIC_INTC_RR_EN
    expv = 3;
`else
    expv = 1;
`endif
    checkOutput("arb_after_1", 32'(irq_vec), 32'(expv));
    for (int r = 0; r < 2; r++) begin
      applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
      idle(1);
    end

    // Disabled source latches pending without requesting.
    applyStimulus('0, 1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, '0, 1'b0, 1'b0);
    idle(4);
    checkOutput("dis_pending", 32'(pending), 32'd1);
    checkOutput("dis_irq", 32'(irq), 32'd0);
    applyStimulus('0, 1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("en_wr_irq", 32'(irq), 32'd0);
    idle(1);
    checkOutput("en_irq", 32'(irq), 32'd1);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);

    // Repeated edge on a pending source is absorbed.
    applyStimulus('0, 1'b1, 4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("absorb_pending", 32'(pending), 32'd0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    idle(4);
    checkOutput("absorb_irq", 32'(irq), 32'd0);

    // Edge landing in the ack cycle survives the clear.
    applyStimulus(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    applyStimulus(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("ack_edge_pending", 32'(pending[2]), 32'd1);

    // Reset during service, then stray handshakes in idle.
    doReset();
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("stray_irq", 32'(irq), 32'd0);
    checkOutput("stray_busy", 32'(busy), 32'd0);

    // Source held high across reset release registers once.
    applyStimulus(4'b0001, 1'b0, '0, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("held_pending", 32'(pending), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(NSRC'($urandom), ($urandom_range(0, 15) == 0), NSRC'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
